vmm_result_buffer: RTL and testbench
====================================

// Module: vmm_result_buffer
// PURPOSE
//  Elastic stage between the VMM engine and the bin2bcd converter. It captures each VMM output
//  element with its (i,j) index tag into a small FIFO. On each operator Next press it pops one
//  entry, starts the BCD converter on it, and holds the value and tags for the HEX displays.
//  This decouples VMM compute rate from the human-paced display stepping.
// PARAMETERS
//  DATA_W       10  width of a VMM result word; matches the bin2bcd No_bits
//  IDX_W        5   width of the i/j index tags
//  DEPTH        8   FIFO entries; power of 2, >=2
//  TIMEOUT_CYC  64  WAIT_CONV watchdog limit, cycles (VMM_BUF_TIMEOUT_EN only)
// PORTS
//  buf_clk      in   1                 single clock, the divided Clk
//  rst_         in   1                 synchronous, active-low reset
//  wr_valid_i   in   1                 VMM result valid this cycle
//  wr_data_i    in   DATA_W            VMM result word
//  wr_i_i       in   IDX_W             row tag
//  wr_j_i       in   IDX_W             column tag
//  full_o       out  1                 FIFO full; VMM stalls while high
//  empty_o      out  1                 FIFO empty
//  count_o      out  $clog2(DEPTH)+1   occupancy, 0..DEPTH
//  overflow_o   out  1                 sticky; a push was dropped
//  next_i       in   1                 operator Next, level; rising edge used internally
//  conv_start_o out  1                 one-cycle start pulse to bin2bcd start_i
//  conv_data_o  out  DATA_W            word under conversion / display
//  conv_done_i  in   1                 bin2bcd done_o
//  disp_i_o     out  IDX_W             tag of the displayed word
//  disp_j_o     out  IDX_W             tag of the displayed word
//  state_o      out  2                 FSM state for HEX debug
//  err_o        out  1                 conversion timed out (VMM_BUF_TIMEOUT_EN only; else 0)
// BEHAVIOUR
//  - Reset (rst_ low at a buf_clk edge) clears the FIFO, pointers, count, overflow_o, err_o and
//    the next/done edge detectors. Outputs at reset:
//      conv_start_o=0, conv_data_o=0, disp_*=0, state_o=IDLE, empty_o=1, full_o=0.
//    Reset overrides every other event in the same cycle, including mid-conversion.
//  - Push: wr_valid_i & (!full_o | pop this cycle) writes at wptr; the word is visible next cycle.
//    Push while full with no pop: word dropped, overflow_o<=1, held until reset.
//  - Pointers are log2(DEPTH) bits and wrap naturally. count_o is +1 on push, -1 on pop, and
//    unchanged on simultaneous push and pop.
//  - next_rise = next_i & ~next_q, where next_q is registered every cycle.
//    done_rise is formed the same way from conv_done_i.
//  - FSM, state_o encoding:
//    IDLE(0): next_rise & !empty -> LAUNCH. next_rise & empty: ignored, no state change.
//    LAUNCH(1): pop the head into conv_data_o/disp_*, conv_start_o=1 for exactly this cycle,
//      then -> WAIT_CONV.
//    WAIT_CONV(2): leave on done_rise -> SHOW. A done level already high at LAUNCH does not
//      count. next_rise is ignored here.
//    SHOW(3): conv_data_o/disp_* are held. next_rise & !empty -> LAUNCH.
//      next_rise & empty -> IDLE; the display holds its last values.
//  - Pop happens only in LAUNCH. Latency from next_rise to conv_start_o is 1 cycle.
//  - Push continues in every state.
// CONFIGURATION
//  VMM_BUF_TIMEOUT_EN defined: a counter runs in WAIT_CONV, reset on entry.
//    At TIMEOUT_CYC cycles without done_rise: -> SHOW and err_o<=1 (sticky until reset).
//  Not defined: no counter, WAIT_CONV waits indefinitely, err_o tied 0.
// TESTING
//  1. Push 3 words (7,i1j2),(512,i4j0),(1023,i0j4); then assert next_i and pulse done.
//     -> Words are popped in FIFO order; each shows conv_start_o as a single-cycle pulse
//        1 cycle after next_rise; disp tags match; count_o goes 3,2,1,0.
//  2. Push DEPTH+1 words with no pops.
//     -> full_o=1 after the 8th push; the 9th is dropped; overflow_o=1; count_o=8.
//  3. Full FIFO, push on the same cycle as the LAUNCH pop.
//     -> Both accepted; count_o stays 8; overflow_o stays 0; FIFO order is preserved.
//  4. Empty FIFO, press next_i.
//     -> No conv_start_o pulse; state_o stays 0. Holding next_i high for 10 cycles after one
//        pop gives exactly one LAUNCH.
//  5. Drive rst_=0 in WAIT_CONV with 4 entries queued.
//     -> Next cycle: state_o=0, count_o=0, empty_o=1, conv_data_o=0.
//        A subsequent done pulse causes no transition.
//  6. With VMM_BUF_TIMEOUT_EN and TIMEOUT_CYC=64, hold conv_done_i=0 after LAUNCH.
//     -> After 64 cycles state_o=3 and err_o=1. Without the macro, state_o stays 2 for 1000 cycles.

Source files
------------

// File: rtl/vmm_result_buffer.sv
// Elastic FIFO between the VMM engine and bin2bcd, with an operator-paced pop/convert/show FSM.
// Optional conversion watchdog enabled by defining VMM_BUF_TIMEOUT_EN.
module vmm_result_buffer #(
  parameter int DATA_W      = 10,
  parameter int IDX_W       = 5,
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   buf_clk,
  input  logic                   rst_,
  input  logic                   wr_valid_i,
  input  logic [DATA_W-1:0]      wr_data_i,
  input  logic [IDX_W-1:0]       wr_i_i,
  input  logic [IDX_W-1:0]       wr_j_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o,
  input  logic                   next_i,
  output logic                   conv_start_o,
  output logic [DATA_W-1:0]      conv_data_o,
  input  logic                   conv_done_i,
  output logic [IDX_W-1:0]       disp_i_o,
  output logic [IDX_W-1:0]       disp_j_o,
  output logic [1:0]             state_o,
  output logic                   err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_W + 2 * IDX_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_SHOW   = 2'd3
  } state_t;

  logic [EW-1:0]     r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_ovf;
  logic              r_next_q;
  logic              r_done_q;
  state_t            r_state;
  logic              r_start;
  logic [DATA_W-1:0] r_data;
  logic [IDX_W-1:0]  r_di;
  logic [IDX_W-1:0]  r_dj;

  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_next_rise;
  logic              w_done_rise;
  logic              w_launch;
  logic [EW-1:0]     w_head;

  // Write side is valid-only: a word is taken when wr_valid_i is high and there is room
  // (or the head leaves in the same cycle); the producer must stall while full_o is high.
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_pop       = (r_state == S_LAUNCH);
  assign w_push      = wr_valid_i & (~w_full | w_pop);
  assign w_next_rise = next_i & ~r_next_q;
  assign w_done_rise = conv_done_i & ~r_done_q;
  assign w_launch    = w_next_rise & ~w_empty & ((r_state == S_IDLE) | (r_state == S_SHOW));
  assign w_head      = r_mem[r_rptr];

  always_ff @(posedge buf_clk) begin
    if (w_push) r_mem[r_wptr] <= {wr_data_i, wr_i_i, wr_j_i};
  end

  always_ff @(posedge buf_clk) begin
    if (!rst_) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_next_q <= 1'b0;
      r_done_q <= 1'b0;
    end else begin
      r_next_q <= next_i;
      r_done_q <= conv_done_i;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push & ~w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop & ~w_push) r_count <= r_count - CW'(1);
      if (wr_valid_i & ~w_push) r_ovf <= 1'b1;
    end
  end

`ifdef VMM_BUF_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0] r_tmo;
  logic          r_err;
`endif

  // The head is latched into the display registers on the edge that enters LAUNCH,
  // so conv_data_o is already valid alongside the start pulse.
  always_ff @(posedge buf_clk) begin
    if (!rst_) begin
      r_state <= S_IDLE;
      r_start <= 1'b0;
      r_data  <= '0;
      r_di    <= '0;
      r_dj    <= '0;
`ifdef VMM_BUF_TIMEOUT_EN
      r_tmo   <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_start <= 1'b0;
      if (w_launch) begin
        r_state               <= S_LAUNCH;
        r_start               <= 1'b1;
        {r_data, r_di, r_dj}  <= w_head;
      end else begin
        case (r_state)
          S_LAUNCH: begin
            r_state <= S_WAIT;
`ifdef VMM_BUF_TIMEOUT_EN
            r_tmo   <= '0;
`endif
          end
          S_WAIT: begin
            if (w_done_rise) r_state <= S_SHOW;
`ifdef VMM_BUF_TIMEOUT_EN
            else if (r_tmo == TW'(TIMEOUT_CYC - 1)) begin
              r_state <= S_SHOW;
              r_err   <= 1'b1;
            end else begin
              r_tmo <= r_tmo + TW'(1);
            end
`endif
          end
          S_SHOW: begin
            if (w_next_rise) r_state <= S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign full_o       = w_full;
  assign empty_o      = w_empty;
  assign count_o      = r_count;
  assign overflow_o   = r_ovf;
  assign conv_start_o = r_start;
  assign conv_data_o  = r_data;
  assign disp_i_o     = r_di;
  assign disp_j_o     = r_dj;
  assign state_o      = r_state;
`ifdef VMM_BUF_TIMEOUT_EN
  assign err_o        = r_err;
`else
  // No watchdog: err_o is constant 0; TIMEOUT_CYC is referenced only to keep it live.
  assign err_o        = (TIMEOUT_CYC < 0);
`endif
endmodule

// File: tb/tb_vmm_result_buffer.sv
// Self-checking bench for vmm_result_buffer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_vmm_result_buffer;
  localparam int DATA_W      = 10;
  localparam int IDX_W       = 5;
  localparam int DEPTH       = 8;
  localparam int TIMEOUT_CYC = 64;
  localparam int EW          = DATA_W + 2 * IDX_W;

  logic                   clk = 1'b0;
  logic                   rst_ = 1'b0;
  logic                   wr_valid_i = 1'b0;
  logic [DATA_W-1:0]      wr_data_i = '0;
  logic [IDX_W-1:0]       wr_i_i = '0;
  logic [IDX_W-1:0]       wr_j_i = '0;
  logic                   full_o;
  logic                   empty_o;
  logic [$clog2(DEPTH):0] count_o;
  logic                   overflow_o;
  logic                   next_i = 1'b0;
  logic                   conv_start_o;
  logic [DATA_W-1:0]      conv_data_o;
  logic                   conv_done_i = 1'b0;
  logic [IDX_W-1:0]       disp_i_o;
  logic [IDX_W-1:0]       disp_j_o;
  logic [1:0]             state_o;
  logic                   err_o;

  vmm_result_buffer #(
    .DATA_W(DATA_W), .IDX_W(IDX_W), .DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .buf_clk(clk), .rst_(rst_), .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i),
    .wr_i_i(wr_i_i), .wr_j_i(wr_j_i), .full_o(full_o), .empty_o(empty_o),
    .count_o(count_o), .overflow_o(overflow_o), .next_i(next_i),
    .conv_start_o(conv_start_o), .conv_data_o(conv_data_o), .conv_done_i(conv_done_i),
    .disp_i_o(disp_i_o), .disp_j_o(disp_j_o), .state_o(state_o), .err_o(err_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, display as the last launched entry.
  logic [EW-1:0]     exp_q[$];
  int                m_state = 0;
  bit                m_ovf = 0, m_err = 0, m_start = 0, m_pn = 0, m_pd = 0;
  int                m_tmo = 0;
  logic [DATA_W-1:0] m_data = '0;
  logic [IDX_W-1:0]  m_di = '0, m_dj = '0;

  task automatic model_step();
    logic [EW-1:0] head;
    int  sz;
    bit  nr, dr;
    if (!rst_) begin
      exp_q.delete();
      m_state = 0; m_ovf = 0; m_err = 0; m_start = 0; m_pn = 0; m_pd = 0; m_tmo = 0;
      m_data = '0; m_di = '0; m_dj = '0;
      return;
    end
    sz = exp_q.size();
    nr = next_i && !m_pn;
    dr = conv_done_i && !m_pd;
    m_pn = next_i;
    m_pd = conv_done_i;
    m_start = 0;
    case (m_state)
      0: if (nr && sz > 0) begin
        m_state = 1; m_start = 1; {m_data, m_di, m_dj} = exp_q[0];
      end
      1: begin
        head = exp_q.pop_front();
        m_state = 2;
        m_tmo = 0;
      end
      2: begin
        if (dr) m_state = 3;
`ifdef VMM_BUF_TIMEOUT_EN
        else begin
          m_tmo++;
          if (m_tmo == TIMEOUT_CYC) begin m_state = 3; m_err = 1; end
        end
`endif
      end
      default: if (nr) begin
        if (sz > 0) begin
          m_state = 1; m_start = 1; {m_data, m_di, m_dj} = exp_q[0];
        end else m_state = 0;
      end
    endcase
    if (wr_valid_i) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({wr_data_i, wr_i_i, wr_j_i});
      else m_ovf = 1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Scoreboard compare, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("state",    state_o,      m_state);
      check("count",    count_o,      exp_q.size());
      check("empty",    empty_o,      exp_q.size() == 0);
      check("full",     full_o,       exp_q.size() == DEPTH);
      check("overflow", overflow_o,   m_ovf);
      check("start",    conv_start_o, m_start);
      check("data",     conv_data_o,  m_data);
      check("disp_i",   disp_i_o,     m_di);
      check("disp_j",   disp_j_o,     m_dj);
      check("err",      err_o,        m_err);
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ = 1'b0; wr_valid_i = 1'b0; next_i = 1'b0; conv_done_i = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    rst_ = 1'b1;
  endtask

  task automatic push(input logic [DATA_W-1:0] d, input logic [IDX_W-1:0] ti, input logic [IDX_W-1:0] tj);
    wr_valid_i = 1'b1; wr_data_i = d; wr_i_i = ti; wr_j_i = tj;
    tick();
    wr_valid_i = 1'b0;
  endtask

  task automatic launch_and_finish(output logic [DATA_W-1:0] d);
    next_i = 1'b1;
    tick();
    d = conv_data_o;
    next_i = 1'b0;
    tick();
    conv_done_i = 1'b1;
    tick();
    conv_done_i = 1'b0;
    tick();
  endtask

  int                lit_d [3] = '{7, 512, 1023};
  int                lit_i [3] = '{1, 4, 0};
  int                lit_j [3] = '{2, 0, 4};
  logic [DATA_W-1:0] w [9];
  logic [DATA_W-1:0] got;
  int                starts;

  initial begin
    do_reset();
    check("rst_state", state_o, 0);
    check("rst_empty", empty_o, 1);
    check("rst_data",  conv_data_o, 0);

    // FIFO order, one-cycle start pulse, tags, count stepping down
    for (int k = 0; k < 3; k++) push(DATA_W'(lit_d[k]), IDX_W'(lit_i[k]), IDX_W'(lit_j[k]));
    check("t1_count3", count_o, 3);
    for (int k = 0; k < 3; k++) begin
      next_i = 1'b1;
      tick();
      check("t1_start", conv_start_o, 1);
      check("t1_data",  conv_data_o, lit_d[k]);
      check("t1_di",    disp_i_o, lit_i[k]);
      check("t1_dj",    disp_j_o, lit_j[k]);
      next_i = 1'b0;
      tick();
      check("t1_start_low", conv_start_o, 0);
      check("t1_count", count_o, 2 - k);
      conv_done_i = 1'b1;
      tick();
      conv_done_i = 1'b0;
      check("t1_show", state_o, 3);
      tick();
    end

    // Overflow: DEPTH+1 pushes, no pops
    do_reset();
    for (int k = 0; k < DEPTH + 1; k++) begin
      push(DATA_W'($urandom), IDX_W'(k), IDX_W'(k));
      if (k == DEPTH - 1) begin
        check("t2_full", full_o, 1);
        check("t2_ovf_before", overflow_o, 0);
      end
    end
    check("t2_ovf", overflow_o, 1);
    check("t2_count", count_o, DEPTH);

    // Push into a full FIFO on the pop cycle
    do_reset();
    for (int k = 0; k < 9; k++) w[k] = DATA_W'($urandom);
    for (int k = 0; k < DEPTH; k++) push(w[k], IDX_W'(k), IDX_W'(k));
    next_i = 1'b1;
    tick();
    check("t3_head", conv_data_o, w[0]);
    next_i = 1'b0;
    wr_valid_i = 1'b1; wr_data_i = w[8]; wr_i_i = 5'd8; wr_j_i = 5'd8;
    tick();
    wr_valid_i = 1'b0;
    check("t3_count", count_o, DEPTH);
    check("t3_ovf", overflow_o, 0);
    conv_done_i = 1'b1;
    tick();
    conv_done_i = 1'b0;
    tick();
    for (int k = 1; k < 9; k++) begin
      launch_and_finish(got);
      check("t3_order", got, w[k]);
    end
    check("t3_empty", empty_o, 1);

    // Next on empty FIFO; held next gives a single launch
    do_reset();
    next_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t4_idle", state_o, 0);
      check("t4_nostart", conv_start_o, 0);
    end
    next_i = 1'b0;
    tick();
    push(10'd100, 5'd1, 5'd1);
    push(10'd200, 5'd2, 5'd2);
    starts = 0;
    next_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) conv_done_i = 1'b1;
      if (c == 4) conv_done_i = 1'b0;
      tick();
      if (conv_start_o) starts++;
    end
    check("t4_one_launch", starts, 1);
    check("t4_show", state_o, 3);
    next_i = 1'b0;
    tick();

    // Reset mid-conversion
    do_reset();
    for (int k = 0; k < 5; k++) push(DATA_W'(k + 30), IDX_W'(k), IDX_W'(k));
    next_i = 1'b1;
    tick();
    next_i = 1'b0;
    tick();
    check("t5_wait", state_o, 2);
    check("t5_count4", count_o, 4);
    rst_ = 1'b0;
    tick();
    rst_ = 1'b1;
    check("t5_state", state_o, 0);
    check("t5_count", count_o, 0);
    check("t5_empty", empty_o, 1);
    check("t5_data", conv_data_o, 0);
    conv_done_i = 1'b1;
    tick();
    conv_done_i = 1'b0;
    tick();
    check("t5_no_move", state_o, 0);

    // Conversion never completes
    do_reset();
    push(10'd321, 5'd3, 5'd7);
    next_i = 1'b1;
    tick();
    next_i = 1'b0;
    tick();
`ifdef VMM_BUF_TIMEOUT_EN
    for (int c = 0; c < TIMEOUT_CYC - 1; c++) tick();
    check("t6_still_wait", state_o, 2);
    tick();
    check("t6_timeout_state", state_o, 3);
    check("t6_err", err_o, 1);
`else
    for (int c = 0; c < 1000; c++) tick();
    check("t6_wait_hold", state_o, 2);
    check("t6_err_zero", err_o, 0);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst_        = ($urandom_range(0, 299) != 0);
      wr_valid_i  = ($urandom_range(0, 1) == 0);
      wr_data_i   = DATA_W'($urandom);
      wr_i_i      = IDX_W'($urandom);
      wr_j_i      = IDX_W'($urandom);
      if ($urandom_range(0, 3) == 0) next_i = ~next_i;
      if ($urandom_range(0, 2) == 0) conv_done_i = ~conv_done_i;
      tick();
    end
    rst_ = 1'b1;
    wr_valid_i = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
